data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 120 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : Word memory controller: one- or two-beat accesses, a fixed
//            wait-state count, and a valid/ready request/response handshake.
// Revision : 1.0
// ============================================================================
module data_mem_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int WAIT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_wide,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATA_W-1:0]   rsp_rdata
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic                  we_q;
  logic                  wide_q;
  logic                  beat;
  logic [ADDR_W-1:0]     addr_q;
  logic [2*DATA_W-1:0]   wdata_q;
  logic [3:0]            wait_cnt;

  // Memory is deliberately outside the reset domain; contents survive rst_n.
  logic [DATA_W-1:0]     mem [DEPTH] = '{default: '0};

  logic                  access;
  logic [ADDR_W-1:0]     beat_addr;
  logic [DATA_W-1:0]     beat_wdata;
  logic [DATA_W-1:0]     rd_word;

  assign access     = (state == BUSY) && (wait_cnt == 4'd0);
  // ADDR_W-bit sum wraps DEPTH-1 back to 0 for the second beat.
  assign beat_addr  = addr_q + {{(ADDR_W-1){1'b0}}, beat};
  assign beat_wdata = beat ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];
  assign rd_word    = mem[beat_addr];

  always_ff @(posedge clk) begin
    if (access && we_q)
      mem[beat_addr] <= beat_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      wait_cnt  <= 4'd0;
      beat      <= 1'b0;
      we_q      <= 1'b0;
      wide_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            wide_q    <= req_wide;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wait_cnt  <= 4'(WAIT);
            beat      <= 1'b0;
            req_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            if (!beat)
              rsp_rdata <= we_q ? '0 : {{DATA_W{1'b0}}, rd_word};
            else if (!we_q)
              rsp_rdata[2*DATA_W-1:DATA_W] <= rd_word;
            if (wide_q && !beat) begin
              beat <= 1'b1;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Brief    : Directed bench over three controller instances (WAIT = 0, 1, 3).
// Revision : 1.0
// ============================================================================
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic        req_wide  [3];
  logic [7:0]  req_addr  [3];
  logic [15:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [15:0] rsp_rdata [3];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Instance 0: WAIT=0, instance 1: WAIT=1 (default), instance 2: WAIT=3.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .WAIT(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_wide  (req_wide[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Present a request, let it be accepted, and wait for rsp_valid.
  // lat = number of rising edges after the accept edge until rsp_valid is seen.
  task automatic send(input int k, input logic we, input logic wide, input logic [7:0] addr,
                      input logic [15:0] wd, output int lat, output logic rdy_low);
    @(negedge clk);
    chk($sformatf("ready_before_req_%0d", k), 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_wide[k]  = wide;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_wdata[k] = 16'hDEAD;
    req_addr[k]  = 8'h5A;
    lat     = 0;
    rdy_low = 1'b1;
    while (!rsp_valid[k] && lat < 40) begin
      if (req_ready[k]) rdy_low = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid[k]) chk("rsp_timeout", 32'(rsp_valid[k]), 32'd1);
  endtask

  task automatic ack(input int k);
    @(negedge clk);
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
  endtask

  task automatic xact(input int k, input logic we, input logic wide, input logic [7:0] addr,
                      input logic [15:0] wd, output logic [15:0] rd, output int lat);
    logic rl;
    send(k, we, wide, addr, wd, lat, rl);
    rd = rsp_rdata[k];
    ack(k);
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] held;
    int          lat;
    logic        rl;
    logic        stable;
    int          cyc;
    int          acc [$];

    for (int i = 0; i < 3; i++) begin
      rst_n[i]     = 1'b0;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_wide[i]  = 1'b0;
      req_addr[i]  = 8'h00;
      req_wdata[i] = 16'h0000;
      rsp_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_req_ready_%0d", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("rst_rsp_valid_%0d", i), 32'(rsp_valid[i]), 32'd0);
      chk($sformatf("rst_rsp_rdata_%0d", i), 32'(rsp_rdata[i]), 32'd0);
    end
    #1;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Wide writes then narrow reads, WAIT=1.
    xact(1, 1'b1, 1'b1, 8'd100, 16'h0101, rd, lat);
    chk("wr_wide_rdata_zero", 32'(rd), 32'h0);
    chk("wr_wide_latency_w1", 32'(lat), 32'd3);
    xact(1, 1'b1, 1'b1, 8'd102, 16'h0504, rd, lat);
    xact(1, 1'b0, 1'b0, 8'd100, 16'hFFFF, rd, lat);
    chk("rd_100", 32'(rd), 32'h0001);
    chk("rd_narrow_latency_w1", 32'(lat), 32'd2);
    xact(1, 1'b0, 1'b0, 8'd101, 16'hFFFF, rd, lat);
    chk("rd_101", 32'(rd), 32'h0001);
    xact(1, 1'b0, 1'b0, 8'd102, 16'hFFFF, rd, lat);
    chk("rd_102", 32'(rd), 32'h0004);
    xact(1, 1'b0, 1'b0, 8'd103, 16'hFFFF, rd, lat);
    chk("rd_103", 32'(rd), 32'h0005);
    xact(1, 1'b0, 1'b1, 8'd101, 16'hFFFF, rd, lat);
    chk("rd_wide_101", 32'(rd), 32'h0401);

    // Address wrap at DEPTH-1.
    xact(1, 1'b1, 1'b1, 8'd255, 16'hBBAA, rd, lat);
    xact(1, 1'b0, 1'b0, 8'd255, 16'h0000, rd, lat);
    chk("wrap_word255", 32'(rd), 32'h00AA);
    xact(1, 1'b0, 1'b0, 8'd0, 16'h0000, rd, lat);
    chk("wrap_word0", 32'(rd), 32'h00BB);
    xact(1, 1'b0, 1'b1, 8'd255, 16'h0000, rd, lat);
    chk("wrap_wide_rd", 32'(rd), 32'hBBAA);

    // WAIT=3 latency; req_ready must stay low while busy.
    xact(2, 1'b1, 1'b1, 8'd7, 16'h9988, rd, lat);
    send(2, 1'b0, 1'b0, 8'd7, 16'h0000, lat, rl);
    chk("w3_narrow_latency", 32'(lat), 32'd4);
    chk("w3_narrow_ready_low", 32'(rl), 32'd1);
    chk("w3_narrow_rdata", 32'(rsp_rdata[2]), 32'h0088);
    ack(2);
    send(2, 1'b0, 1'b1, 8'd7, 16'h0000, lat, rl);
    chk("w3_wide_latency", 32'(lat), 32'd5);
    chk("w3_wide_ready_low", 32'(rl), 32'd1);
    chk("w3_wide_rdata", 32'(rsp_rdata[2]), 32'h9988);
    ack(2);

    // Response held with rsp_ready low; request pulses must be ignored.
    send(1, 1'b0, 1'b1, 8'd100, 16'h0000, lat, rl);
    held   = rsp_rdata[1];
    stable = 1'b1;
    chk("hold_initial_rdata", 32'(held), 32'h0101);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid[1] = i[0];
      req_we[1]    = 1'b1;
      req_wide[1]  = 1'b1;
      req_addr[1]  = 8'd100;
      req_wdata[1] = 16'hFFFF;
      @(posedge clk);
      #1;
      if (!rsp_valid[1] || rsp_rdata[1] !== held || req_ready[1]) stable = 1'b0;
    end
    req_valid[1] = 1'b0;
    chk("hold_stable", 32'(stable), 32'd1);
    ack(1);
    #1;
    chk("hold_released_valid", 32'(rsp_valid[1]), 32'd0);
    xact(1, 1'b0, 1'b1, 8'd100, 16'h0000, rd, lat);
    chk("hold_no_array_change", 32'(rd), 32'h0101);

    // Throughput with rsp_ready tied high, WAIT=0.
    rsp_ready[0] = 1'b1;
    for (int w = 0; w < 2; w++) begin
      acc.delete();
      cyc = 0;
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_wide[0]  = w[0];
      req_addr[0]  = 8'd20;
      while (cyc < 16) begin
        if (req_ready[0]) acc.push_back(cyc);
        @(negedge clk);
        cyc++;
      end
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk($sformatf("tput_accepts_w%0d", w), 32'(acc.size() >= 3), 32'd1);
      if (acc.size() >= 3) begin
        chk($sformatf("tput_gap1_w%0d", w), 32'(acc[1] - acc[0]), 32'(3 + w));
        chk($sformatf("tput_gap2_w%0d", w), 32'(acc[2] - acc[1]), 32'(3 + w));
      end
      repeat (3) @(negedge clk);
    end
    rsp_ready[0] = 1'b0;

    // Reset after beat 0 of a wide write, WAIT=0.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_wide[0]  = 1'b1;
    req_addr[0]  = 8'd10;
    req_wdata[0] = 16'h3322;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("abort_rsp_rdata", 32'(rsp_rdata[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("abort_rsp_valid_held", 32'(rsp_valid[0]), 32'd0);
    #1;
    rst_n[0] = 1'b1;
    xact(0, 1'b0, 1'b0, 8'd10, 16'h0000, rd, lat);
    chk("post_reset_first_edge_accept", 32'(lat), 32'd1);
    chk("abort_word10", 32'(rd), 32'h0022);
    xact(0, 1'b0, 1'b0, 8'd11, 16'h0000, rd, lat);
    chk("abort_word11_unwritten", 32'(rd), 32'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL global_timeout observed=running expected=finished");
  end

endmodule
`default_nettype wire
